// File: rtl/wb_uart_lite_pkg.sv
// Shared constants, types and helpers for the Wishbone UART and its RX engine.
package wb_uart_lite_pkg;

    // Word offsets decoded from ADR[3:2]
    localparam logic [1:0] RegData   = 2'd0;
    localparam logic [1:0] RegStatus = 2'd1;
    localparam logic [1:0] RegIer    = 2'd2;
    localparam logic [1:0] RegDiv    = 2'd3;

    // STATUS bit positions
    localparam int unsigned StDr   = 0;
    localparam int unsigned StOe   = 1;
    localparam int unsigned StFe   = 2;
    localparam int unsigned StThre = 5;
    localparam int unsigned StTemt = 6;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

    // Rounded clocks-per-bit for the reset baud rate.
    function automatic logic [15:0] calc_div0(input int unsigned clk_mhz,
                                              input int unsigned baud);
        int unsigned clk_hz;
        clk_hz = clk_mhz * 32'd1000000;
        return 16'((clk_hz + baud / 32'd2) / baud);
    endfunction

endpackage

// File: rtl/wb_uart_lite_if.sv
// Wishbone B3 slave signal bundle for the UART; names follow the SoC port list.
interface wb_uart_lite_if;
    logic [31:0] UART_ADR_I;
    logic [31:0] UART_DAT_I;
    logic [31:0] UART_DAT_O;
    logic        UART_STB_I;
    logic        UART_CYC_I;
    logic        UART_WE_I;
    logic [3:0]  UART_SEL_I;
    logic [2:0]  UART_CTI_I;
    logic [1:0]  UART_BTE_I;
    logic        UART_LOCK_I;
    logic        UART_ACK_O;
    logic        UART_RTY_O;
    logic        UART_ERR_O;

    modport master (
        output UART_ADR_I, UART_DAT_I, UART_STB_I, UART_CYC_I, UART_WE_I, UART_SEL_I,
               UART_CTI_I, UART_BTE_I, UART_LOCK_I,
        input  UART_DAT_O, UART_ACK_O, UART_RTY_O, UART_ERR_O
    );

    modport slave (
        input  UART_ADR_I, UART_DAT_I, UART_STB_I, UART_CYC_I, UART_WE_I, UART_SEL_I,
               UART_CTI_I, UART_BTE_I, UART_LOCK_I,
        output UART_DAT_O, UART_ACK_O, UART_RTY_O, UART_ERR_O
    );
endinterface

// File: rtl/uart_rx_engine.sv
// 8N1 receiver: input synchronizer, start validation at mid-bit, LSB-first shift.
module uart_rx_engine
    import wb_uart_lite_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sin_i,
    input  logic [15:0] div_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    output logic        rx_fe_o
);

    logic        sync1_q, sin_q;
    uart_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] len_q, len_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        armed_q, armed_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sin_q   <= 1'b1;
            state_q <= StIdle;
            cnt_q   <= '0;
            len_q   <= 16'd2;
            bit_q   <= '0;
            shift_q <= '0;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= sin_i;
            sin_q   <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            armed_q <= armed_d;
        end
    end

    // Bit length is latched at each boundary so a divisor change never splits a bit.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 16'd1;
        len_d      = len_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        armed_d    = armed_q;
        rx_valid_o = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!armed_q) begin
                    armed_d = sin_q;
                end else if (!sin_q) begin
                    state_d = StStart;
                    len_d   = div_i;
                end
            end
            StStart: begin
                if (cnt_q == (len_q >> 1) - 16'd1) begin
                    cnt_d = '0;
                    len_d = div_i;
                    if (sin_q) begin
                        state_d = StIdle;
                        armed_d = 1'b0;
                    end else begin
                        state_d = StData;
                        bit_d   = '0;
                    end
                end
            end
            StData: begin
                if (cnt_q == len_q - 16'd1) begin
                    cnt_d   = '0;
                    len_d   = div_i;
                    shift_d = {sin_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (cnt_q == len_q - 16'd1) begin
                    rx_valid_o = 1'b1;
                    state_d    = StIdle;
                    armed_d    = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign rx_data_o = shift_q;
    assign rx_fe_o   = ~sin_q;

endmodule

// File: rtl/wb_uart_lite.sv
// Wishbone B3 slave UART, 8N1 without FIFO: bus registers, TX shifter and interrupt.
module wb_uart_lite
    import wb_uart_lite_pkg::*;
#(
    parameter int unsigned CLK_IN_MHZ = 50,
    parameter int unsigned BAUD_RATE  = 576000
) (
    input  logic          CLK,
    input  logic          RESET_N,
    wb_uart_lite_if.slave bus,
    output logic          INTR,
    input  logic          SIN,
    output logic          RXRDY_N,
    output logic          SOUT,
    output logic          TXRDY_N
);

    localparam logic [15:0] Div0 = calc_div0(CLK_IN_MHZ, BAUD_RATE);

    logic        ack_q, we_q, sel_nz_q;
    logic [1:0]  adr_q;
    logic [15:0] wdat_q;
    logic [1:0]  ier_q;
    logic [15:0] div_q;
    logic [7:0]  thr_q, rbr_q;
    logic        dr_q, oe_q, fe_q, thre_q, temt_q, intr_q;
    logic [31:0] rdata;
    logic        req, wr, rd, thr_wr, data_rd, stat_rd, oe_set, fe_set;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_fe;

    uart_state_e tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, tx_len_q, tx_len_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        sout_q, sout_d, tx_load, tx_done;

    logic unused_bus;
    assign unused_bus = ^{bus.UART_ADR_I[31:4], bus.UART_ADR_I[1:0], bus.UART_DAT_I[31:16],
                          bus.UART_CTI_I, bus.UART_BTE_I, bus.UART_LOCK_I};

    // The request is captured so side effects in the ACK cycle use its own attributes.
    assign req     = bus.UART_STB_I & bus.UART_CYC_I & ~ack_q;
    assign wr      = ack_q & we_q & sel_nz_q;
    assign rd      = ack_q & ~we_q;
    assign thr_wr  = wr & (adr_q == RegData) & thre_q;
    assign data_rd = rd & (adr_q == RegData);
    assign stat_rd = rd & (adr_q == RegStatus);
    assign oe_set  = rx_valid & dr_q & ~data_rd;
    assign fe_set  = rx_valid & rx_fe;

    uart_rx_engine u_rx (
        .clk_i      (CLK),
        .rst_ni     (RESET_N),
        .sin_i      (SIN),
        .div_i      (div_q),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .rx_fe_o    (rx_fe)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ack_q    <= 1'b0;
            adr_q    <= '0;
            we_q     <= 1'b0;
            sel_nz_q <= 1'b0;
            wdat_q   <= '0;
            ier_q    <= '0;
            div_q    <= Div0;
            thr_q    <= '0;
            rbr_q    <= '0;
            dr_q     <= 1'b0;
            oe_q     <= 1'b0;
            fe_q     <= 1'b0;
            thre_q   <= 1'b1;
            temt_q   <= 1'b1;
            intr_q   <= 1'b0;
        end else begin
            ack_q <= req;
            if (req) begin
                adr_q    <= bus.UART_ADR_I[3:2];
                we_q     <= bus.UART_WE_I;
                sel_nz_q <= |bus.UART_SEL_I;
                wdat_q   <= bus.UART_DAT_I[15:0];
            end
            if (wr && adr_q == RegIer) ier_q <= wdat_q[1:0];
            if (wr && adr_q == RegDiv) div_q <= (wdat_q < 16'd2) ? 16'd2 : wdat_q;
            if (thr_wr) thr_q <= wdat_q[7:0];
            if (tx_load) thre_q <= 1'b1;
            else if (thr_wr) thre_q <= 1'b0;
            if (tx_load) temt_q <= 1'b0;
            else if (tx_done) temt_q <= 1'b1;
            if (rx_valid) rbr_q <= rx_data;
            if (rx_valid) dr_q <= 1'b1;
            else if (data_rd) dr_q <= 1'b0;
            if (oe_set) oe_q <= 1'b1;
            else if (stat_rd) oe_q <= 1'b0;
            if (fe_set) fe_q <= 1'b1;
            else if (stat_rd) fe_q <= 1'b0;
            intr_q <= (ier_q[0] & dr_q) | (ier_q[1] & thre_q);
        end
    end

    always_comb begin
        rdata = '0;
        case (adr_q)
            RegData:   rdata[7:0] = rbr_q;
            RegStatus: begin
                rdata[StDr]   = dr_q;
                rdata[StOe]   = oe_q;
                rdata[StFe]   = fe_q;
                rdata[StThre] = thre_q;
                rdata[StTemt] = temt_q;
            end
            RegIer:    rdata[1:0] = ier_q;
            RegDiv:    rdata[15:0] = div_q;
            default:   rdata = '0;
        endcase
    end

    assign bus.UART_DAT_O = ack_q ? rdata : 32'd0;
    assign bus.UART_ACK_O = ack_q;
    assign bus.UART_RTY_O = 1'b0;
    assign bus.UART_ERR_O = 1'b0;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tx_state_q <= StIdle;
            tx_cnt_q   <= '0;
            tx_len_q   <= Div0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            sout_q     <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_len_q   <= tx_len_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            sout_q     <= sout_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 16'd1;
        tx_len_d   = tx_len_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        sout_d     = sout_q;
        tx_load    = 1'b0;
        tx_done    = 1'b0;
        if (tx_state_q == StIdle) begin
            tx_cnt_d = '0;
            sout_d   = 1'b1;
            if (!thre_q) begin
                tx_load    = 1'b1;
                tx_state_d = StStart;
                tx_len_d   = div_q;
                tx_shift_d = thr_q;
                sout_d     = 1'b0;
            end
        end else if (tx_cnt_q == tx_len_q - 16'd1) begin
            tx_cnt_d = '0;
            tx_len_d = div_q;
            case (tx_state_q)
                StStart: begin
                    tx_state_d = StData;
                    tx_bit_d   = '0;
                    sout_d     = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                end
                StData: begin
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = StStop;
                        sout_d     = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        sout_d     = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                    end
                end
                StStop: begin
                    // A pending THR starts the next frame with no idle gap.
                    if (!thre_q) begin
                        tx_load    = 1'b1;
                        tx_state_d = StStart;
                        tx_shift_d = thr_q;
                        sout_d     = 1'b0;
                    end else begin
                        tx_done    = 1'b1;
                        tx_state_d = StIdle;
                        sout_d     = 1'b1;
                    end
                end
                default: tx_state_d = StIdle;
            endcase
        end
    end

    assign SOUT    = sout_q;
    assign INTR    = intr_q;
    assign RXRDY_N = ~dr_q;
    assign TXRDY_N = ~thre_q;

endmodule

// File: tb/tb_wb_uart_lite.sv
// Directed bench for wb_uart_lite: register table plus TX/RX/interrupt/reset sequences.
module tb_wb_uart_lite;
    import wb_uart_lite_pkg::*;

    logic clk, rst_n, sin, intr, rxrdy_n, sout, txrdy_n;
    int   n_vec, n_bad;

    wb_uart_lite_if bus ();

    wb_uart_lite #(.CLK_IN_MHZ(50), .BAUD_RATE(576000)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus),
        .INTR    (intr),
        .SIN     (sin),
        .RXRDY_N (rxrdy_n),
        .SOUT    (sout),
        .TXRDY_N (txrdy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic wb_access(input logic we, input logic [3:0] adr, input logic [31:0] wdat,
                             input logic [3:0] sel, output logic [31:0] rdat);
        int lat;
        lat  = 0;
        rdat = '0;
        @(negedge clk);
        bus.UART_STB_I = 1'b1;
        bus.UART_CYC_I = 1'b1;
        bus.UART_WE_I  = we;
        bus.UART_ADR_I = {28'h0, adr};
        bus.UART_DAT_I = wdat;
        bus.UART_SEL_I = sel;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.UART_ACK_O !== 1'b1 && lat < 8);
        rdat = bus.UART_DAT_O;
        bus.UART_STB_I = 1'b0;
        bus.UART_CYC_I = 1'b0;
        bus.UART_WE_I  = 1'b0;
        check("ack_latency", 32'(lat), 32'd1);
        @(negedge clk);
        check("ack_one_cycle", {31'd0, bus.UART_ACK_O}, 32'd0);
        check("dat_o_idle", bus.UART_DAT_O, 32'd0);
    endtask

    task automatic wb_wr(input logic [3:0] adr, input logic [31:0] wdat);
        logic [31:0] r;
        wb_access(1'b1, adr, wdat, 4'hF, r);
    endtask

    task automatic wb_rd(input string name, input logic [3:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        wb_access(1'b0, adr, 32'd0, 4'hF, r);
        check(name, r, exp);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int per);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            sin = fr[k];
            repeat (per - 1) @(negedge clk);
        end
        @(negedge clk);
        sin = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [9:0]  frame;
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        sin   = 1'b1;
        bus.UART_ADR_I  = '0;
        bus.UART_DAT_I  = '0;
        bus.UART_STB_I  = 1'b0;
        bus.UART_CYC_I  = 1'b0;
        bus.UART_WE_I   = 1'b0;
        bus.UART_SEL_I  = '0;
        bus.UART_CTI_I  = '0;
        bus.UART_BTE_I  = '0;
        bus.UART_LOCK_I = 1'b0;

        // {we, byte address, write data, sel, expected read data}
        tbl.push_back('{1'b0, 4'h4, 32'h0,      4'hF, 32'h00000060});
        tbl.push_back('{1'b0, 4'hC, 32'h0,      4'hF, 32'h00000057});
        tbl.push_back('{1'b0, 4'h8, 32'h0,      4'hF, 32'h00000000});
        tbl.push_back('{1'b0, 4'h0, 32'h0,      4'hF, 32'h00000000});
        tbl.push_back('{1'b1, 4'h8, 32'hFF,     4'hF, 32'h0});
        tbl.push_back('{1'b0, 4'h8, 32'h0,      4'hF, 32'h00000003});
        tbl.push_back('{1'b1, 4'h8, 32'h0,      4'hF, 32'h0});
        tbl.push_back('{1'b1, 4'hC, 32'h0,      4'hF, 32'h0});
        tbl.push_back('{1'b0, 4'hC, 32'h0,      4'hF, 32'h00000002});
        tbl.push_back('{1'b1, 4'hC, 32'h1,      4'h1, 32'h0});
        tbl.push_back('{1'b0, 4'hC, 32'h0,      4'hF, 32'h00000002});
        tbl.push_back('{1'b1, 4'hC, 32'h1234,   4'h0, 32'h0});
        tbl.push_back('{1'b0, 4'hC, 32'h0,      4'hF, 32'h00000002});
        tbl.push_back('{1'b1, 4'hC, 32'hABCD000A, 4'hF, 32'h0});
        tbl.push_back('{1'b0, 4'hC, 32'h0,      4'hF, 32'h0000000A});
        tbl.push_back('{1'b1, 4'h4, 32'hFF,     4'hF, 32'h0});
        tbl.push_back('{1'b0, 4'h4, 32'h0,      4'hF, 32'h00000060});
        tbl.push_back('{1'b1, 4'hC, 32'd87,     4'hF, 32'h0});
        tbl.push_back('{1'b0, 4'hC, 32'h0,      4'hF, 32'h00000057});

        repeat (3) @(negedge clk);
        check("rst_sout", {31'd0, sout}, 32'd1);
        check("rst_txrdy_n", {31'd0, txrdy_n}, 32'd0);
        check("rst_rxrdy_n", {31'd0, rxrdy_n}, 32'd1);
        check("rst_intr", {31'd0, intr}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (tbl[i]) begin
            wb_access(tbl[i].we, tbl[i].adr, tbl[i].wdat, tbl[i].sel, r);
            if (!tbl[i].we) check($sformatf("table_rd_%0d", i), r, tbl[i].exp);
        end

        // TX 0xA5 at 87 clocks per bit
        wb_wr(4'h0, 32'hA5);
        check("tx_thre_clear", {31'd0, txrdy_n}, 32'd1);
        @(negedge clk);
        check("tx_thre_set", {31'd0, txrdy_n}, 32'd0);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int t = 0; t < 880; t++) begin
            if (t == 86) check("tx_start_end", {31'd0, sout}, 32'd0);
            if (t == 87) check("tx_bit0_begin", {31'd0, sout}, 32'd1);
            if (t % 87 == 43 && t / 87 < 10)
                check($sformatf("tx_a5_bit%0d", t / 87), {31'd0, sout}, {31'd0, frame[t/87]});
            @(negedge clk);
        end
        wb_rd("tx_temt", 4'h4, 32'h00000060);

        // RX 0x3C
        send_frame(8'h3C, 1'b1, 87);
        check("rx_rxrdy_n", {31'd0, rxrdy_n}, 32'd0);
        wb_rd("rx_status", 4'h4, 32'h00000061);
        wb_rd("rx_data", 4'h0, 32'h0000003C);
        wb_rd("rx_dr_clear", 4'h4, 32'h00000060);
        check("rx_rxrdy_n_clr", {31'd0, rxrdy_n}, 32'd1);

        // Overrun then framing error
        send_frame(8'h11, 1'b1, 87);
        send_frame(8'h22, 1'b0, 87);
        wb_rd("oe_fe_status", 4'h4, 32'h00000067);
        wb_rd("oe_data", 4'h0, 32'h00000022);
        wb_rd("oe_fe_cleared", 4'h4, 32'h00000060);

        // RX-data interrupt
        wb_wr(4'h8, 32'h1);
        send_frame(8'h5A, 1'b1, 87);
        check("rx_intr_set", {31'd0, intr}, 32'd1);
        wb_rd("rx_intr_data", 4'h0, 32'h0000005A);
        @(negedge clk);
        check("rx_intr_clear", {31'd0, intr}, 32'd0);

        // THRE interrupt dips for one cycle around the THR transfer
        wb_wr(4'h8, 32'h2);
        @(negedge clk);
        check("thre_intr_idle", {31'd0, intr}, 32'd1);
        wb_wr(4'h0, 32'h00);
        check("thre_intr_lag", {31'd0, intr}, 32'd1);
        @(negedge clk);
        check("thre_intr_dip", {31'd0, intr}, 32'd0);
        @(negedge clk);
        check("thre_intr_back", {31'd0, intr}, 32'd1);
        wb_wr(4'h8, 32'h0);
        repeat (900) @(negedge clk);

        // Divisor 10: TX bit period and RX glitch rejection
        wb_wr(4'hC, 32'd10);
        wb_wr(4'h0, 32'h01);
        @(negedge clk);
        check("div10_start", {31'd0, sout}, 32'd0);
        repeat (9) @(negedge clk);
        check("div10_start_end", {31'd0, sout}, 32'd0);
        @(negedge clk);
        check("div10_bit0", {31'd0, sout}, 32'd1);
        repeat (10) @(negedge clk);
        check("div10_bit1", {31'd0, sout}, 32'd0);
        repeat (120) @(negedge clk);
        sin = 1'b0;
        repeat (4) @(negedge clk);
        sin = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_rxrdy_n", {31'd0, rxrdy_n}, 32'd1);
        wb_rd("glitch_status", 4'h4, 32'h00000060);
        send_frame(8'hC3, 1'b1, 10);
        wb_rd("div10_rx_data", 4'h0, 32'h000000C3);

        // Asynchronous reset in the middle of a TX frame with RX data pending
        wb_wr(4'hC, 32'd87);
        wb_wr(4'h8, 32'h2);
        send_frame(8'h77, 1'b1, 87);
        wb_wr(4'h0, 32'h00);
        repeat (100) @(negedge clk);
        check("pre_rst_sout", {31'd0, sout}, 32'd0);
        check("pre_rst_rxrdy_n", {31'd0, rxrdy_n}, 32'd0);
        check("pre_rst_intr", {31'd0, intr}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sout", {31'd0, sout}, 32'd1);
        check("mid_rst_txrdy_n", {31'd0, txrdy_n}, 32'd0);
        check("mid_rst_rxrdy_n", {31'd0, rxrdy_n}, 32'd1);
        check("mid_rst_intr", {31'd0, intr}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wb_rd("post_rst_status", 4'h4, 32'h00000060);
        wb_rd("post_rst_div", 4'hC, 32'h00000057);
        wb_rd("post_rst_ier", 4'h8, 32'h00000000);
        check("post_rst_sout", {31'd0, sout}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
